// File: rtl/dkong3_sub_dma_if.sv
// dkong3_sub_dma_if -- bus bundle between the sub-CPU/APU side and the DMA block.
//   slave  : the DMA block (takes CPU/DMC/ROM inputs, drives CE/PHI2/RDY/ROM/DMC outputs)
//   master : the surrounding system (CPU, APU, ROM, or a testbench)
// Signals:
//   I_CPU_ADDR[15:0]  sub-CPU address        I_CPU_RNW      CPU read(1)/write(0)
//   I_DMC_REQ         DMC DMA request        I_DMC_ADDR     DMC sample fetch address
//   I_ROM_DATA[7:0]   ROM data (1-clk lat)   O_CPU_CE       one-clock CPU/APU enable
//   O_PHI2            PHI2 phase             O_ODD_OR_EVEN  APU cycle parity
//   O_CPU_RDY         CPU ready (0 = halt)   O_ROM_ADDR     ROM address (CPU or DMA)
//   O_DMC_ACK         DMA byte delivered     O_DMC_DATA     DMA byte to APU
interface dkong3_sub_dma_if;
    logic [15:0] I_CPU_ADDR;
    logic        I_CPU_RNW;
    logic        I_DMC_REQ;
    logic [15:0] I_DMC_ADDR;
    logic [7:0]  I_ROM_DATA;
    logic        O_CPU_CE;
    logic        O_PHI2;
    logic        O_ODD_OR_EVEN;
    logic        O_CPU_RDY;
    logic [15:0] O_ROM_ADDR;
    logic        O_DMC_ACK;
    logic [7:0]  O_DMC_DATA;

    modport slave (
        input  I_CPU_ADDR, I_CPU_RNW, I_DMC_REQ, I_DMC_ADDR, I_ROM_DATA,
        output O_CPU_CE, O_PHI2, O_ODD_OR_EVEN, O_CPU_RDY, O_ROM_ADDR, O_DMC_ACK, O_DMC_DATA
    );

    modport master (
        output I_CPU_ADDR, I_CPU_RNW, I_DMC_REQ, I_DMC_ADDR, I_ROM_DATA,
        input  O_CPU_CE, O_PHI2, O_ODD_OR_EVEN, O_CPU_RDY, O_ROM_ADDR, O_DMC_ACK, O_DMC_DATA
    );
endinterface

// File: rtl/dkong3_sub_dma.sv
// dkong3_sub_dma -- sub-CPU clock enable generator plus APU DMC sample DMA.
// Divides I_SUBCLK by CE_DIV into a one-clock CPU enable, derives PHI2 and the
// APU odd/even cycle parity, and steals 3 or 4 CPU cycles to fetch one DMC
// sample byte from ROM (HALT, DUMMY, optional ALIGN, FETCH).
// Ports:
//   I_SUBCLK  sole clock (rising edge)
//   I_RESET   synchronous active-high reset
//   bus       dkong3_sub_dma_if.slave (CPU/DMC/ROM inputs, CE/PHI2/RDY/ROM/DMC outputs)
module dkong3_sub_dma #(
    parameter int CE_DIV = 12   // I_SUBCLK clocks per CPU cycle, 4..32
) (
    input  logic             I_SUBCLK,
    input  logic             I_RESET,
    dkong3_sub_dma_if.slave  bus
);
    localparam int CW = $clog2(CE_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_DUMMY,
        S_ALIGN,
        S_FETCH
    } state_t;

    logic [CW-1:0] div_cnt;
    logic          ce;
    logic          phi2;
    logic          parity;
    state_t        state;
    state_t        state_nxt;
    logic          rdy;
    logic          fetch;
    logic          ack;
    logic [7:0]    dmc_data;

    // ---------------- clock enable / phase ----------------
    assign ce   = (div_cnt == CW'(CE_DIV - 1));
    assign phi2 = (div_cnt >= CW'(CE_DIV / 2));

    always_ff @(posedge I_SUBCLK) begin
        if (I_RESET)
            div_cnt <= '0;
        else if (ce)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + CW'(1);
    end

    always_ff @(posedge I_SUBCLK) begin
        if (I_RESET)
            parity <= 1'b0;
        else if (ce)
            parity <= ~parity;
    end

    // ---------------- DMA FSM ----------------
    always_ff @(posedge I_SUBCLK) begin
        if (I_RESET)
            state <= S_IDLE;
        else if (ce)
            state <= state_nxt;
    end

    // Only consulted on CE clocks. A dropped request abandons the DMA from any
    // halted state; FETCH always finishes its cycle and returns to IDLE, so a
    // request still high there needs a fresh IDLE CE to start again.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.I_DMC_REQ && bus.I_CPU_RNW) state_nxt = S_HALT;
            S_HALT:  state_nxt = bus.I_DMC_REQ ? S_DUMMY : S_IDLE;
            S_DUMMY: begin
                if (!bus.I_DMC_REQ)
                    state_nxt = S_IDLE;
                else if (!parity)
                    state_nxt = S_FETCH;
                else
                    state_nxt = S_ALIGN;
            end
            S_ALIGN: state_nxt = bus.I_DMC_REQ ? S_FETCH : S_IDLE;
            S_FETCH: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rdy   = (state == S_IDLE);
        fetch = (state == S_FETCH);
        ack   = fetch && ce && bus.I_DMC_REQ;
    end

    // ROM data arrives one clock after the address, so keep capturing for the
    // whole FETCH cycle; the last captured byte is the one acknowledged.
    always_ff @(posedge I_SUBCLK) begin
        if (I_RESET)
            dmc_data <= 8'h00;
        else if (fetch)
            dmc_data <= bus.I_ROM_DATA;
    end

    // ---------------- outputs ----------------
    // Reset is synchronous for state, but outputs are forced to their reset
    // values for every clock I_RESET is high, including the first one.
    assign bus.O_CPU_CE      = ce && !I_RESET;
    assign bus.O_PHI2        = phi2 && !I_RESET;
    assign bus.O_ODD_OR_EVEN = parity && !I_RESET;
    assign bus.O_CPU_RDY     = rdy || I_RESET;
    assign bus.O_DMC_ACK     = ack && !I_RESET;
    assign bus.O_DMC_DATA    = I_RESET ? 8'h00 : dmc_data;
    assign bus.O_ROM_ADDR    = (fetch && !I_RESET) ? bus.I_DMC_ADDR : bus.I_CPU_ADDR;
endmodule

// File: tb/tb_dkong3_sub_dma.sv
// tb_dkong3_sub_dma -- directed bench for dkong3_sub_dma with a cycle model.
// The model counts clocks since reset and treats a DMA as "busy for N CPU
// cycles, last one is the fetch"; a compare process checks every output on
// every falling edge, and directed scenarios pin the model with literals.
module tb_dkong3_sub_dma;
    localparam int CE_DIV = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dkong3_sub_dma_if bus ();

    dkong3_sub_dma #(.CE_DIV(CE_DIV)) dut (
        .I_SUBCLK (clk),
        .I_RESET  (rst),
        .bus      (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [7:0] rom_fn(input logic [15:0] a);
        rom_fn = (a == 16'hC123) ? 8'h5A : (a[7:0] ^ a[15:8]);
    endfunction

    // ROM with one clock of latency
    logic [7:0] rom_q;
    always @(posedge clk) rom_q <= rom_fn(bus.O_ROM_ADDR);
    assign bus.I_ROM_DATA = rom_q;

    // ---------------- behavioural model ----------------
    int         k = 0;          // clocks since the last reset clock
    bit         m_par = 1'b0;   // CPU cycles since reset, mod 2
    bit         m_busy = 1'b0;  // CPU halted for a DMA
    int         m_rem = 0;      // CPU cycles left in the DMA, 1 = fetch cycle
    logic [7:0] m_data = 8'h00;
    logic [7:0] m_rom_q = 8'h00;
    bit         mc_ce, mc_f;

    always @(posedge clk) begin
        mc_ce = (k % CE_DIV) == CE_DIV - 1;
        mc_f  = m_busy && m_rem == 1;
        if (rst) begin
            k = 0; m_par = 1'b0; m_busy = 1'b0; m_rem = 0; m_data = 8'h00;
        end else begin
            if (mc_f) m_data = m_rom_q;
            if (mc_ce) begin
                if (m_busy) begin
                    if (!bus.I_DMC_REQ || m_rem == 1) m_busy = 1'b0;
                    else m_rem--;
                end else if (bus.I_DMC_REQ && bus.I_CPU_RNW) begin
                    m_busy = 1'b1;
                    // the DUMMY cycle sees the same parity as the start cycle
                    m_rem  = m_par ? 4 : 3;
                end
                m_par = !m_par;
            end
            k++;
        end
        m_rom_q = rom_fn((mc_f && !rst) ? bus.I_DMC_ADDR : bus.I_CPU_ADDR);
    end

    bit cp_ce, cp_f;
    always @(negedge clk) begin
        if (chk_en) begin
            cp_ce = (k % CE_DIV) == CE_DIV - 1;
            cp_f  = m_busy && m_rem == 1;
            chk("m_ce",   bus.O_CPU_CE,      !rst && cp_ce);
            chk("m_phi2", bus.O_PHI2,        !rst && (k % CE_DIV) >= CE_DIV / 2);
            chk("m_par",  bus.O_ODD_OR_EVEN, !rst && m_par);
            chk("m_rdy",  bus.O_CPU_RDY,     rst || !m_busy);
            chk("m_rom",  bus.O_ROM_ADDR,    (!rst && cp_f) ? bus.I_DMC_ADDR : bus.I_CPU_ADDR);
            chk("m_ack",  bus.O_DMC_ACK,     !rst && cp_f && cp_ce && bus.I_DMC_REQ);
            chk("m_data", bus.O_DMC_DATA,    rst ? 8'h00 : m_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // advance into the next cycle whose closing edge is a CE clock
    task automatic ce_window();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * CE_DIV; i++) begin
            tick();
            if (bus.O_CPU_CE) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_chk++;
            $display("FAIL ce_timeout: no O_CPU_CE within %0d clocks at %0t", 2 * CE_DIV, $time);
        end
    endtask

    task automatic run_dma(input bit want_par, input logic [15:0] daddr,
                           output int n_low, output bit acked,
                           output logic [7:0] adata, output logic [15:0] aaddr);
        n_low = 0; acked = 1'b0; adata = 8'h00; aaddr = 16'h0000;
        bus.I_DMC_ADDR = daddr;
        bus.I_CPU_RNW  = 1'b1;
        ce_window();
        if (bus.O_ODD_OR_EVEN != want_par) ce_window();
        bus.I_DMC_REQ = 1'b1;
        for (int i = 0; i < 6 && !acked; i++) begin
            ce_window();
            if (!bus.O_CPU_RDY) n_low++;
            if (bus.O_DMC_ACK) begin
                acked = 1'b1;
                adata = bus.O_DMC_DATA;
                aaddr = bus.O_ROM_ADDR;
            end
        end
        tick();                 // request still high across the closing CE
        bus.I_DMC_REQ = 1'b0;
    endtask

    int          n, per, hi, n_low;
    bit          acked, prev_par;
    logic [7:0]  adata;
    logic [15:0] aaddr;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.I_CPU_ADDR = 16'h8000;
        bus.I_CPU_RNW  = 1'b1;
        bus.I_DMC_REQ  = 1'b0;
        bus.I_DMC_ADDR = 16'hC123;
        rst = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;

        // reset state
        bus.I_CPU_ADDR = 16'h1234;
        tick();
        chk("rst_ce",   bus.O_CPU_CE, 0);
        chk("rst_phi2", bus.O_PHI2, 0);
        chk("rst_par",  bus.O_ODD_OR_EVEN, 0);
        chk("rst_rdy",  bus.O_CPU_RDY, 1);
        chk("rst_ack",  bus.O_DMC_ACK, 0);
        chk("rst_data", bus.O_DMC_DATA, 8'h00);
        chk("rst_rom",  bus.O_ROM_ADDR, 16'h1234);
        bus.I_CPU_ADDR = 16'h8000;

        // release: first CE clock is CE_DIV clocks after the last reset clock
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); n++;
            if (bus.O_CPU_CE) break;
        end
        chk("first_ce_clk", n + 1, 12);

        // free run: period, PHI2 duty, parity alternation
        for (int p = 0; p < 10; p++) begin
            prev_par = bus.O_ODD_OR_EVEN;
            per = 0; hi = 0;
            for (int i = 0; i < 40; i++) begin
                tick(); per++;
                if (bus.O_PHI2) hi++;
                if (bus.O_CPU_CE) break;
            end
            chk("ce_period", per, 12);
            chk("phi2_high", hi, 6);
            chk("par_alt",   bus.O_ODD_OR_EVEN, !prev_par);
        end

        // DMA, DUMMY on an even cycle: 3 halted cycles
        run_dma(1'b0, 16'hC123, n_low, acked, adata, aaddr);
        chk("even_low",  n_low, 3);
        chk("even_ack",  acked, 1);
        chk("even_data", adata, 8'h5A);
        chk("even_addr", aaddr, 16'hC123);
        chk("even_rdy",  bus.O_CPU_RDY, 1);

        // DMA, DUMMY on an odd cycle: ALIGN inserted, 4 halted cycles
        run_dma(1'b1, 16'hC123, n_low, acked, adata, aaddr);
        chk("odd_low",  n_low, 4);
        chk("odd_ack",  acked, 1);
        chk("odd_data", adata, 8'h5A);

        // different sample address
        run_dma(1'b0, 16'hD2F0, n_low, acked, adata, aaddr);
        chk("d2_data", adata, 8'h22);
        chk("d2_addr", aaddr, 16'hD2F0);

        // request during a write cycle waits for the next read CE
        bus.I_DMC_ADDR = 16'hC123;
        bus.I_CPU_RNW  = 1'b0;
        ce_window();
        bus.I_DMC_REQ = 1'b1;
        ce_window();
        chk("wr_idle_rdy", bus.O_CPU_RDY, 1);
        bus.I_CPU_RNW = 1'b1;
        tick();
        chk("wr_halt_rdy", bus.O_CPU_RDY, 0);
        acked = 1'b0;
        for (int i = 0; i < 6 && !acked; i++) begin
            ce_window();
            if (bus.O_DMC_ACK) acked = 1'b1;
        end
        tick();
        bus.I_DMC_REQ = 1'b0;
        chk("wr_ack", acked, 1);

        // request dropped in DUMMY: back to IDLE, no ACK, data untouched
        bus.I_DMC_ADDR = 16'hE0F0;
        ce_window();
        bus.I_DMC_REQ = 1'b1;
        ce_window();                     // HALT cycle
        chk("ab_halt_rdy", bus.O_CPU_RDY, 0);
        ce_window();                     // DUMMY cycle
        bus.I_DMC_REQ = 1'b0;
        tick();
        chk("ab_rdy",  bus.O_CPU_RDY, 1);
        chk("ab_ack",  bus.O_DMC_ACK, 0);
        chk("ab_data", bus.O_DMC_DATA, 8'h5A);

        // reset pulsed during FETCH
        bus.I_DMC_ADDR = 16'hC123;
        ce_window();
        bus.I_DMC_REQ = 1'b1;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!bus.O_CPU_RDY && bus.O_ROM_ADDR == 16'hC123) break;
            n++;
        end
        chk("fetch_seen", (n < 100), 1);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("rf_ack0", bus.O_DMC_ACK, 0);
        tick();
        bus.I_DMC_REQ = 1'b0;
        chk("rf_rdy",  bus.O_CPU_RDY, 1);
        chk("rf_ack",  bus.O_DMC_ACK, 0);
        chk("rf_data", bus.O_DMC_DATA, 8'h00);
        chk("rf_ce",   bus.O_CPU_CE, 0);
        chk("rf_phi2", bus.O_PHI2, 0);
        chk("rf_par",  bus.O_ODD_OR_EVEN, 0);
        chk("rf_rom",  bus.O_ROM_ADDR, 16'h8000);
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(); n++;
            if (bus.O_CPU_CE) break;
        end
        chk("rf_first_ce", n + 1, 12);
        tick();
        chk("rf_idle", bus.O_CPU_RDY, 1);

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/dkong3_sub_dma.md
DKONG3_SUB_DMA -- requirements
Module: dkong3_sub_dma

Interface
REQ-001 Parameter CE_DIV, default 12: I_SUBCLK clocks per sub-CPU cycle; legal range 4..32.
REQ-002 I_SUBCLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 I_RESET  in  1  synchronous, active-high reset.
REQ-004 I_CPU_ADDR  in  16  sub-CPU address bus.
REQ-005 I_CPU_RNW  in  1  sub-CPU read (1) / write (0).
REQ-006 I_DMC_REQ  in  1  APU DMC DMA request.
REQ-007 I_DMC_ADDR  in  16  APU DMC sample fetch address.
REQ-008 I_ROM_DATA  in  8  sub ROM read data, valid 1 clock after O_ROM_ADDR.
REQ-009 O_CPU_CE  out  1  one-clock CPU/APU cycle enable.
REQ-010 O_PHI2  out  1  PHI2 phase to APU.
REQ-011 O_ODD_OR_EVEN  out  1  APU cycle parity.
REQ-012 O_CPU_RDY  out  1  CPU ready; 0 halts CPU.
REQ-013 O_ROM_ADDR  out  16  ROM address, CPU or DMA.
REQ-014 O_DMC_ACK  out  1  DMA byte delivered.
REQ-015 O_DMC_DATA  out  8  DMA byte to APU.

Function
REQ-016 Divider counter runs 0..CE_DIV-1 and wraps; O_CPU_CE is 1 only on the clock where counter = CE_DIV-1.
REQ-017 O_PHI2 is 1 for counter >= CE_DIV/2 (integer division) and 0 otherwise.
REQ-018 O_ODD_OR_EVEN toggles on every O_CPU_CE clock.
REQ-019 The DMA FSM has states IDLE, HALT, DUMMY, ALIGN and FETCH, and changes state only on O_CPU_CE clocks.
REQ-020 IDLE->HALT when I_DMC_REQ=1 and I_CPU_RNW=1 on a CE clock; a request during a CPU write cycle waits in IDLE for the next read cycle.
REQ-021 HALT->DUMMY unconditionally.
REQ-022 DUMMY->FETCH if O_ODD_OR_EVEN=0 on that CE clock, otherwise DUMMY->ALIGN; ALIGN->FETCH unconditionally.
REQ-023 FETCH->IDLE unconditionally, so a DMA occupies 3 or 4 CPU cycles.
REQ-024 O_CPU_RDY = 0 whenever state != IDLE, and = 1 in IDLE.
REQ-025 O_ROM_ADDR = I_DMC_ADDR while in FETCH; otherwise O_ROM_ADDR = I_CPU_ADDR.
REQ-026 O_DMC_DATA registers I_ROM_DATA on every clock in FETCH and holds its value in all other states.
REQ-027 O_DMC_ACK = 1 only on the CE clock that ends FETCH, and lasts exactly one clock.
REQ-028 If I_DMC_REQ falls before FETCH ends, the FSM returns to IDLE on the next CE clock with no ACK; data is not updated after that point.
REQ-029 A request still high on the CE clock that leaves FETCH is ignored on that clock; a new DMA requires a fresh IDLE CE clock.
REQ-030 Address, RNW and request inputs are sampled only on CE clocks; values between CE clocks have no effect on state.

Reset
REQ-031 While I_RESET=1: divider counter = 0, FSM = IDLE, O_CPU_CE = 0, O_PHI2 = 0, O_ODD_OR_EVEN = 0, O_CPU_RDY = 1, O_DMC_ACK = 0, O_DMC_DATA = 0x00, O_ROM_ADDR = I_CPU_ADDR.
REQ-032 A reset asserted mid-DMA aborts the DMA immediately with no ACK.
REQ-033 After reset release, the first O_CPU_CE occurs CE_DIV clocks after the release clock.

Verification
REQ-034 CE_DIV=12, free run for 10 CPU cycles -> O_CPU_CE period is 12 clocks, PHI2 is high for 6 clocks per cycle, and parity alternates.
REQ-035 REQ=1 with RNW=1, DMC_ADDR=0xC123 and ROM[0xC123]=0x5A, parity making DUMMY even -> RDY low for 3 CE cycles, ROM_ADDR=0xC123 during FETCH, ACK=1 for one clock with DMC_DATA=0x5A.
REQ-036 Same stimulus with the opposite parity -> ALIGN is inserted and RDY stays low for 4 CE cycles before ACK.
REQ-037 REQ rises during a write cycle (RNW=0) -> HALT is entered only on the first following read CE.
REQ-038 REQ deasserted while in DUMMY -> IDLE on the next CE, no ACK, RDY returns to 1.
REQ-039 I_RESET pulsed during FETCH -> all outputs return to their reset values, no ACK, and the first CE occurs 12 clocks after release.
